mmc3_irq_unit: RTL and testbench

//  Scanline IRQ stage for MMC3-family mappers. It sits between the PPU bus and the mapper register file.
//  It filters PPU A12 rising edges into scanline clocks and runs the 8-bit reload/decrement counter.
//  It drives the level IRQ onto map_out. The mapper top decodes $C000-$E001 and forwards them as strobes.

---
 rtl/mmc3_irq_pkg.sv | 24 ++
 rtl/mmc3_a12_filter.sv | 48 ++++
 rtl/mmc3_irq_unit.sv | 136 +++++++++++++
 tb/tb_mmc3_irq_unit.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmc3_irq_pkg.sv
// Shared codes for the MMC3 scanline IRQ unit: register selects, save-state addresses, flag bits.
// Build option: define MMC3_IRQ_REVA_EN for the old-revision (NEC) IRQ set rule.
package mmc3_irq_pkg;

  typedef enum logic [1:0] {
    REG_LATCH   = 2'd0,
    REG_RELOAD  = 2'd1,
    REG_DISABLE = 2'd2,
    REG_ENABLE  = 2'd3
  } reg_sel_e;

  typedef enum logic [1:0] {
    SS_COUNT = 2'd0,
    SS_LATCH = 2'd1,
    SS_FLAGS = 2'd2,
    SS_HIST  = 2'd3
  } ss_addr_e;

  // Bit positions inside the save-state flags byte {4'b0, irq, enable, reload, 1'b0}
  localparam int FLAG_RELOAD = 1;
  localparam int FLAG_ENABLE = 2;
  localparam int FLAG_IRQ    = 3;

endpackage

// File: rtl/mmc3_a12_filter.sv
// PPU A12 rise filter: a rise counts only after A12_LOW_MIN consecutive low samples.
// Emits a registered one-cycle clk_pulse; freeze holds the history and suppresses pulses.
module mmc3_a12_filter #(
  parameter int A12_LOW_MIN = 3
) (
  input  logic                 m2,
  input  logic                 map_rst_n,
  input  logic                 freeze,
  input  logic                 a12,
  input  logic                 hist_wr,
  input  logic [A12_LOW_MIN:0] hist_din,
  output logic [A12_LOW_MIN:0] hist,
  output logic                 clk_pulse
);

  localparam int HW = A12_LOW_MIN + 1;

  logic [HW-1:0] hist_q, hist_d;
  logic          pulse_q, pulse_d;
  logic          accept;

  // Newest sample lives in bit 0; the bits above it are the preceding samples.
  always_comb begin
    hist_d  = hist_q;
    pulse_d = 1'b0;
    accept  = a12 && (hist_q[A12_LOW_MIN-1:0] == '0);
    if (hist_wr) begin
      hist_d = hist_din;
    end else if (!freeze) begin
      hist_d  = {hist_q[HW-2:0], a12};
      pulse_d = accept;
    end
  end

  always_ff @(posedge m2 or negedge map_rst_n) begin
    if (!map_rst_n) begin
      hist_q  <= '1;
      pulse_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      pulse_q <= pulse_d;
    end
  end

  assign hist      = hist_q;
  assign clk_pulse = pulse_q & ~freeze;

endmodule

// File: rtl/mmc3_irq_unit.sv
// MMC3 scanline IRQ stage: A12 filter, reload/decrement counter, level IRQ and save-state port.
// Build option: define MMC3_IRQ_REVA_EN for the old-revision (NEC) IRQ set rule.
module mmc3_irq_unit
  import mmc3_irq_pkg::*;
#(
  parameter int A12_LOW_MIN = 3
) (
  input  logic       m2,
  input  logic       map_rst_n,
  input  logic       ppu_a12,
  input  logic       reg_we,
  input  logic [1:0] reg_sel,
  input  logic [7:0] reg_din,
  input  logic       ss_act,
  input  logic       ss_we,
  input  logic [1:0] ss_addr,
  input  logic [7:0] ss_din,
  output logic [7:0] ss_dout,
  output logic       irq,
  output logic       a12_clk
);

  localparam int HW = A12_LOW_MIN + 1;

  logic [7:0]    count_q, count_d;
  logic [7:0]    latch_q, latch_d;
  logic          reload_q, reload_d;
  logic          enable_q, enable_d;
  logic          irq_q, irq_d;
  logic          irq_set;
  logic          hist_wr;
  logic [HW-1:0] hist;
  logic [7:0]    flags;
  logic [7:0]    hist_rd;

  mmc3_a12_filter #(
    .A12_LOW_MIN(A12_LOW_MIN)
  ) u_filter (
    .m2       (m2),
    .map_rst_n(map_rst_n),
    .freeze   (ss_act),
    .a12      (ppu_a12),
    .hist_wr  (hist_wr),
    .hist_din (ss_din[HW-1:0]),
    .hist     (hist),
    .clk_pulse(a12_clk)
  );

  // Clock update runs first so register writes in the same cycle override it.
  always_comb begin
    count_d  = count_q;
    latch_d  = latch_q;
    reload_d = reload_q;
    enable_d = enable_q;
    irq_d    = irq_q;
    irq_set  = 1'b0;
    hist_wr  = 1'b0;
    if (ss_act) begin
      if (ss_we) begin
        case (ss_addr_e'(ss_addr))
          SS_COUNT: count_d = ss_din;
          SS_LATCH: latch_d = ss_din;
          SS_FLAGS: begin
            irq_d    = ss_din[FLAG_IRQ];
            enable_d = ss_din[FLAG_ENABLE];
            reload_d = ss_din[FLAG_RELOAD];
          end
          SS_HIST:  hist_wr = 1'b1;
          default:  hist_wr = 1'b0;
        endcase
      end
    end else begin
      if (a12_clk) begin
        if (count_q == 8'd0 || reload_q) begin
          count_d  = latch_q;
          reload_d = 1'b0;
        end else begin
          count_d = count_q - 8'd1;
        end
`ifdef MMC3_IRQ_REVA_EN
        irq_set = (count_d == 8'd0) && enable_q && ((count_q != 8'd0) || reload_q);
`else
        irq_set = (count_d == 8'd0) && enable_q;
`endif
        if (irq_set) irq_d = 1'b1;
      end
      if (reg_we) begin
        case (reg_sel_e'(reg_sel))
          REG_LATCH:   latch_d = reg_din;
          REG_RELOAD:  reload_d = 1'b1;
          REG_DISABLE: begin
            enable_d = 1'b0;
            irq_d    = 1'b0;
          end
          REG_ENABLE:  enable_d = 1'b1;
          default:     enable_d = enable_q;
        endcase
      end
    end
  end

  always_ff @(posedge m2 or negedge map_rst_n) begin
    if (!map_rst_n) begin
      count_q  <= 8'd0;
      latch_q  <= 8'd0;
      reload_q <= 1'b0;
      enable_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      latch_q  <= latch_d;
      reload_q <= reload_d;
      enable_q <= enable_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    flags              = 8'd0;
    flags[FLAG_IRQ]    = irq_q;
    flags[FLAG_ENABLE] = enable_q;
    flags[FLAG_RELOAD] = reload_q;
    hist_rd            = 8'hFF;
    hist_rd[HW-1:0]    = hist;
    case (ss_addr_e'(ss_addr))
      SS_COUNT: ss_dout = count_q;
      SS_LATCH: ss_dout = latch_q;
      SS_FLAGS: ss_dout = flags;
      SS_HIST:  ss_dout = hist_rd;
      default:  ss_dout = 8'd0;
    endcase
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_mmc3_irq_unit.sv
// Bench for mmc3_irq_unit: vector table, directed corner sequences and a random run vs a reference model.
module tb_mmc3_irq_unit;

  localparam int LOWMIN = 3;
  localparam logic [7:0] HIST_ZERO_RD = 8'(8'hFF << (LOWMIN + 1));

  logic       m2 = 1'b0;
  logic       map_rst_n;
  logic       ppu_a12;
  logic       reg_we;
  logic [1:0] reg_sel;
  logic [7:0] reg_din;
  logic       ss_act;
  logic       ss_we;
  logic [1:0] ss_addr;
  logic [7:0] ss_din;
  logic [7:0] ss_dout;
  logic       irq;
  logic       a12_clk;

  mmc3_irq_unit #(.A12_LOW_MIN(LOWMIN)) dut (
    .m2(m2), .map_rst_n(map_rst_n), .ppu_a12(ppu_a12),
    .reg_we(reg_we), .reg_sel(reg_sel), .reg_din(reg_din),
    .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr), .ss_din(ss_din),
    .ss_dout(ss_dout), .irq(irq), .a12_clk(a12_clk)
  );

  always #5 m2 = ~m2;

  int checks = 0;
  int failures = 0;
  int nclk = 0;

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference model: state kept as plain values; the A12 filter is a run length of low samples.
  logic [7:0] m_cnt, m_latch;
  logic       m_rl, m_en, m_irq, m_pulse;
  int         m_zrun;

  function automatic void m_reset();
    m_cnt = 8'd0; m_latch = 8'd0; m_rl = 1'b0; m_en = 1'b0;
    m_irq = 1'b0; m_pulse = 1'b0; m_zrun = 0;
  endfunction

  function automatic void m_step();
    logic [7:0] old_cnt;
    logic       old_rl;
    logic       fire;
    int         z;
    if (!map_rst_n) begin
      m_reset();
      return;
    end
    if (ss_act) begin
      if (ss_we) begin
        case (ss_addr)
          2'd0: m_cnt = ss_din;
          2'd1: m_latch = ss_din;
          2'd2: begin m_irq = ss_din[3]; m_en = ss_din[2]; m_rl = ss_din[1]; end
          default: begin
            z = 0;
            while (z < LOWMIN && ss_din[z] == 1'b0) z++;
            m_zrun = z;
          end
        endcase
      end
      m_pulse = 1'b0;
    end else begin
      if (m_pulse) begin
        old_cnt = m_cnt;
        old_rl  = m_rl;
        if (m_cnt == 8'd0 || m_rl) begin
          m_cnt = m_latch;
          m_rl  = 1'b0;
        end else begin
          m_cnt = m_cnt - 8'd1;
        end
        fire = (m_cnt == 8'd0) && m_en;
`ifdef MMC3_IRQ_REVA_EN
        fire = fire && (old_cnt != 8'd0 || old_rl);
`endif
        if (fire) m_irq = 1'b1;
      end
      if (reg_we) begin
        case (reg_sel)
          2'd0: m_latch = reg_din;
          2'd1: m_rl = 1'b1;
          2'd2: begin m_en = 1'b0; m_irq = 1'b0; end
          default: m_en = 1'b1;
        endcase
      end
      m_pulse = ppu_a12 && (m_zrun >= LOWMIN);
      m_zrun  = ppu_a12 ? 0 : ((m_zrun < LOWMIN) ? m_zrun + 1 : LOWMIN);
    end
  endfunction

  function automatic logic [7:0] m_dout(input logic [1:0] a);
    case (a)
      2'd0: return m_cnt;
      2'd1: return m_latch;
      default: return {4'b0, m_irq, m_en, m_rl, 1'b0};
    endcase
  endfunction

  // One m2 cycle: enter at negedge with inputs set, check 1 unit after posedge, return at negedge.
  task automatic cyc();
    @(posedge m2);
    m_step();
    #1;
    chk1("model_irq", irq, m_irq);
    chk1("model_a12_clk", a12_clk, m_pulse);
    if (ss_addr != 2'd3) chk8("model_ss_dout", ss_dout, m_dout(ss_addr));
    if (a12_clk) nclk++;
    @(negedge m2);
  endtask

  task automatic wr(input logic [1:0] sel, input logic [7:0] d);
    reg_we = 1'b1; reg_sel = sel; reg_din = d;
    cyc();
    reg_we = 1'b0;
  endtask

  task automatic ssw(input logic [1:0] a, input logic [7:0] d);
    ss_act = 1'b1; ss_we = 1'b1; ss_addr = a; ss_din = d;
    cyc();
    ss_we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    ss_addr = a;
    #1;
    d = ss_dout;
  endtask

  task automatic pulse(input int lo, input int hi);
    ppu_a12 = 1'b0;
    repeat (lo) cyc();
    ppu_a12 = 1'b1;
    repeat (hi) cyc();
  endtask

  typedef struct {
    logic       ss, rw, sw;
    logic [1:0] sel;
    logic [7:0] din;
    logic [1:0] rd;
    logic [7:0] exp;
    logic       irq;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [7:0] v;
    int n0;
    logic exp_fire;

    tbl[0] = '{1'b0, 1'b1, 1'b0, 2'd0, 8'h5A, 2'd1, 8'h5A, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 2'd1, 8'h00, 2'd2, 8'h02, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 2'd3, 8'h00, 2'd2, 8'h06, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 2'd2, 8'h00, 2'd2, 8'h02, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 2'd0, 8'h33, 2'd0, 8'h33, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 2'd0, 8'h0E, 2'd2, 8'h0E, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 2'd0, 8'hF1, 2'd2, 8'h00, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 2'd0, 8'h00, 2'd3, HIST_ZERO_RD, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h11, 2'd1, 8'h5A, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 8'h33, 1'b0};

    map_rst_n = 1'b0; ppu_a12 = 1'b0; reg_we = 1'b0; reg_sel = 2'd0; reg_din = 8'd0;
    ss_act = 1'b0; ss_we = 1'b0; ss_addr = 2'd0; ss_din = 8'd0;
    m_reset();
    @(negedge m2);

    // Reset state
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      chk8("reset_ss_dout", v, (a == 3) ? 8'hFF : 8'h00);
    end
    chk1("reset_irq", irq, 1'b0);
    chk1("reset_a12_clk", a12_clk, 1'b0);
    @(negedge m2);
    map_rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 10; i++) begin
      ss_act = tbl[i].ss; reg_we = tbl[i].rw; reg_sel = tbl[i].sel; reg_din = tbl[i].din;
      ss_we = tbl[i].sw; ss_din = tbl[i].din; ss_addr = tbl[i].rd;
      cyc();
      chk8("table_dout", ss_dout, tbl[i].exp);
      chk1("table_irq", irq, tbl[i].irq);
      reg_we = 1'b0; ss_we = 1'b0;
    end
    ss_act = 1'b0;

    // Basic countdown
    wr(2'd0, 8'd5); wr(2'd1, 8'd0); wr(2'd3, 8'd0);
    for (int i = 0; i < 8; i++) begin
      pulse(8, 4);
      rd(2'd0, v);
      chk8("t1_count", v, (i < 6) ? 8'(5 - i) : 8'(5 - (i - 6)));
      chk1("t1_irq", irq, (i >= 5));
    end
    wr(2'd2, 8'd0);
    chk1("t1_ack", irq, 1'b0);

    // Short low run is ignored, exact minimum is accepted
    n0 = nclk;
    pulse(LOWMIN - 1, 4);
    rd(2'd0, v);
    chk8("t2_short_count", v, 8'd4);
    chk8("t2_short_clks", 8'(nclk - n0), 8'd0);
    pulse(LOWMIN, 4);
    rd(2'd0, v);
    chk8("t2_min_count", v, 8'd3);
    chk8("t2_min_clks", 8'(nclk - n0), 8'd1);

    // Latch of zero
    wr(2'd0, 8'd0); wr(2'd1, 8'd0); wr(2'd3, 8'd0);
    for (int i = 0; i < 3; i++) begin
      pulse(8, 4);
`ifdef MMC3_IRQ_REVA_EN
      exp_fire = (i == 0);
`else
      exp_fire = 1'b1;
`endif
      chk1("t3_irq", irq, exp_fire);
      wr(2'd2, 8'd0); wr(2'd3, 8'd0);
    end

    // Same-cycle $E000 and $C001 against a12_clk
    wr(2'd2, 8'd0); wr(2'd1, 8'd0); wr(2'd3, 8'd0);
    ppu_a12 = 1'b0;
    repeat (8) cyc();
    ppu_a12 = 1'b1;
    cyc();
    chk1("t4_clk_a", a12_clk, 1'b1);
    wr(2'd2, 8'd0);
    chk1("t4_e000_wins", irq, 1'b0);
    ppu_a12 = 1'b0;
    repeat (8) cyc();
    ppu_a12 = 1'b1;
    cyc();
    chk1("t4_clk_b", a12_clk, 1'b1);
    wr(2'd1, 8'd0);
    rd(2'd2, v);
    chk8("t4_c001_wins", v, 8'h02);

    // Save-state freeze
    n0 = nclk;
    ssw(2'd0, 8'h22);
    ssw(2'd2, 8'h0C);
    for (int i = 0; i < 20; i++) pulse(8, 4);
    rd(2'd0, v);
    chk8("t5_frozen_count", v, 8'h22);
    chk8("t5_frozen_clks", 8'(nclk - n0), 8'd0);
    ss_act = 1'b0;
    pulse(8, 4);
    rd(2'd0, v);
    chk8("t5_resume_count", v, 8'h21);
    chk1("t5_irq_held", irq, 1'b1);
    wr(2'd2, 8'd0);
    chk1("t5_ack", irq, 1'b0);

    // Asynchronous reset mid-frame
    ssw(2'd0, 8'd7);
    ssw(2'd2, 8'h08);
    ss_act = 1'b0;
    chk1("t6_irq_before", irq, 1'b1);
    ppu_a12 = 1'b1;
    #2;
    map_rst_n = 1'b0;
    m_reset();
    #1;
    chk1("t6_irq_async", irq, 1'b0);
    rd(2'd0, v);
    chk8("t6_count_async", v, 8'd0);
    @(negedge m2);
    cyc();
    map_rst_n = 1'b1;
    n0 = nclk;
    repeat (4) cyc();
    chk8("t6_no_clk", 8'(nclk - n0), 8'd0);

    // Random run against the model
    ppu_a12 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) ppu_a12 = ~ppu_a12;
      if ($urandom_range(0, 39) == 0) ss_act = ~ss_act;
      ss_we   = ss_act && ($urandom_range(0, 7) == 0);
      ss_addr = 2'($urandom_range(0, 3));
      ss_din  = 8'($urandom);
      reg_we  = ($urandom_range(0, 9) == 0);
      reg_sel = 2'($urandom_range(0, 3));
      reg_din = 8'($urandom_range(0, 4));
      cyc();
    end
    reg_we = 1'b0; ss_we = 1'b0; ss_act = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
